mips_divider: RTL

- Multi-cycle restoring divider for MIPS DIV/DIVU; produces LO (quotient) and HI (remainder) for the HI/LO register file.
- Inverse operation of the ALU's ripple adder: one trial subtraction per cycle, WIDTH cycles per divide.
- Sits beside the ALU in the execute stage.
- Pipeline stalls on busy and captures results on done.

---
 rtl/mips_div_pkg.sv | 20 ++
 rtl/mips_divider_div_step.sv | 31 +++
 rtl/mips_divider.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_div_pkg
// Purpose  : Shared state encoding and constants for the MIPS DIV/DIVU divider.
// Revision : 1.0  initial release
// ============================================================================
package mips_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [DEFAULT_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/mips_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One restoring-division iteration: shift in a dividend bit, try
//            to subtract the divisor, keep the result only if it is non-negative.
// Revision : 1.0  initial release
// ============================================================================
module div_step
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  assign w_shifted = {rem_in, bit_in};
  assign w_trial   = w_shifted - {1'b0, divisor};

  // rem_in < divisor always holds, so the trial MSB is a clean borrow flag.
  assign q_bit   = ~w_trial[WIDTH];
  assign rem_out = q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mips_divider.sv
`default_nettype none
// ============================================================================
// Module   : mips_divider
// Purpose  : Multi-cycle restoring divider producing LO/HI for MIPS DIV/DIVU.
//            Signed DIV support is built only with `define DIVIDER_SIGNED_EN.
// Revision : 1.0  initial release
// ============================================================================
module mips_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] c_zero_quot = WIDTH'(DIV_ZERO_QUOT);
  localparam logic [CNT_W-1:0] c_last_cnt  = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dz;

  logic [WIDTH-1:0] w_rem_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_div_mag;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (r_rem),
    .bit_in  (r_q[WIDTH-1]),
    .divisor (r_div),
    .rem_out (w_rem_next),
    .q_bit   (w_qbit)
  );

  assign w_q_next = {r_q[WIDTH-2:0], w_qbit};

`ifdef DIVIDER_SIGNED_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_dvd;
  logic             w_dvd_neg;
  logic             w_div_neg;

  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_div_neg = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_div_mag = w_div_neg ? -divisor : divisor;

  // Divide-by-zero reports the untouched dividend, so its sign fixup is skipped.
  assign w_q_fin = r_dz ? c_zero_quot : (r_neg_q ? -w_q_next : w_q_next);
  assign w_r_fin = r_dz ? r_dvd : (r_neg_r ? -w_rem_next : w_rem_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dvd   <= '0;
    end else if (r_state == IDLE && start) begin
      r_neg_q <= w_dvd_neg ^ w_div_neg;
      r_neg_r <= w_dvd_neg;
      r_dvd   <= dividend;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = is_signed;
  assign w_dvd_mag       = dividend;
  assign w_div_mag       = divisor;
  // With a zero divisor every trial succeeds, leaving the dividend as remainder.
  assign w_q_fin = r_dz ? c_zero_quot : w_q_next;
  assign w_r_fin = w_rem_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_dz        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_q     <= w_dvd_mag;
            r_div   <= w_div_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_dz    <= (divisor == '0);
            busy    <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_last_cnt) begin
            quotient    <= w_q_fin;
            remainder   <= w_r_fin;
            div_by_zero <= r_dz;
            busy        <= 1'b0;
            done        <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
